lsb_mem_port: RTL
=================

Name: lsb_mem_port

Overview:
In-order load/store queue that is the initiator on memory-controller port 1. Port 0 is the instruction fetcher's read-only path; this block adds the data path beside it. It accepts load/store ops from the decoder, issues them one at a time on the rw_flag/addr/len/data/busy/done handshake, and returns load data or store completion, with its tag, to the ROB and reservation stations. It mirrors the fetcher's use of the same controller interface, and adds writes and sub-word access.

Parameters:
DEPTH, 4, queue entries (power of 2, >=2)
ADDR_WIDTH, 32, address width (`addrWidth)
DATA_WIDTH, 32, data width (`dataWidth)
TAG_WIDTH, 4, ROB tag width (`tagWidth)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
alloc_en  in  1  enqueue one op this cycle
alloc_op  in  4  {is_store, is_unsigned, size[1:0]}; size 0=byte, 1=half, 3=word (2 reserved, treated as word)
alloc_addr  in  ADDR_WIDTH  byte address (alignment not checked)
alloc_data  in  DATA_WIDTH  store data; ignored for loads
alloc_tag  in  TAG_WIDTH  destination ROB tag
lsb_free  out  1  1 when count < DEPTH-1 (one slot of margin for the in-flight fetch)
rw_flag  out  2  00 idle, 01 read, 10 write (to mem_ctrl port 1)
addr  out  ADDR_WIDTH  request address
len  out  2  bytes-1: 0, 1 or 3
data_out  out  DATA_WIDTH  store data; controller uses the low len+1 bytes
data_in  in  DATA_WIDTH  read data, valid while done=1
mem_busy  in  1  controller is serving the other port
mem_done  in  1  one-cycle pulse: current request finished
rst_en  out  1  one-cycle result valid
rst_tag  out  TAG_WIDTH  tag of the completed op
rst_data  out  DATA_WIDTH  extended load data; 0 for stores

Behaviour:
- Reset (async, immediate): queue empty, head=tail=count=0, state IDLE, rw_flag=00, addr=0, len=0, data_out=0, rst_en=0, rst_tag=0, rst_data=0, lsb_free=1.
- Queue: circular FIFO, head/tail wrap modulo DEPTH.
  - alloc_en with count<DEPTH writes at tail and increments tail.
  - alloc_en at count==DEPTH is dropped; state unchanged (bench flags it as a protocol error).
  - Enqueue and pop in the same cycle leave count unchanged; both pointers advance.
- FSM states: IDLE, REQ, GAP. All request outputs are registered.
  - IDLE: if count>0 at the clock edge, latch the head entry into addr/len/data_out, set rw_flag (01 load, 10 store) and go to REQ. An op enqueued at cycle N is on rw_flag no earlier than N+1.
  - REQ: hold rw_flag/addr/len/data_out stable, regardless of mem_busy, until mem_done=1.
  - On mem_done in REQ, at the next edge:
    - pop the head and clear rw_flag to 00;
    - assert rst_en for exactly one cycle with rst_tag = head tag;
    - rst_data = data_in extended per op, or 0 for stores;
    - go to GAP.
  - GAP: rw_flag stays 00 for exactly one cycle so the controller sees a deassert between requests. Next edge: REQ with the new head if count>0, else IDLE. Throughput is at most one op per (controller latency + 2) cycles.
  - mem_done outside REQ is ignored.
- Load extension: byte takes data_in[7:0], half takes [15:0], word takes all 32 bits. Signed ops sign-extend from bit 7/15; unsigned ops zero-fill. is_unsigned is ignored for words and stores.
- Enqueue in the same cycle as a GAP-to-REQ decision: the newly enqueued op is not issued ahead of older entries; strict FIFO order always.
- lsb_free is combinational from count.

Test Plan:
- Reset then idle: no alloc for 20 cycles -> rw_flag=00, rst_en=0, lsb_free=1 throughout; reset asserted mid-REQ -> rw_flag=00 immediately and lsb_free=1.
- Signed byte load: addr 0x104, op {0,0,00}, tag 3; responder returns done with data_in=0x000000F0 after 3 cycles -> one rst_en pulse, tag 3, rst_data 0xFFFFFFF0. Same load with is_unsigned=1 -> 0x000000F0.
- Word store: addr 0x30000, data 0x41, tag 5 -> rw_flag=10 and len=3 held until done; then rst_en with tag 5, rst_data 0, and rw_flag=00 for exactly one cycle.
- Back-to-back: enqueue 4 ops (tags 1-4) on consecutive cycles -> lsb_free drops after the 3rd; results come in order 1,2,3,4, each separated by a GAP cycle; 5th alloc while full is dropped.
- Busy contention: hold mem_busy=1 for 10 cycles during REQ -> addr/len/rw_flag stay stable and no result until done.
- Half load 0x8001 unsigned vs signed -> 0x00008001 and 0xFFFF8001; a spurious done pulse in IDLE produces no rst_en.

Source files
------------

// File: rtl/lsb_mem_port.sv
// In-order load/store queue driving memory-controller port 1.
// Ops are issued one at a time; each result is returned with its ROB tag.
module lsb_mem_port #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_en,
    input  logic [3:0]            alloc_op,
    input  logic [ADDR_WIDTH-1:0] alloc_addr,
    input  logic [DATA_WIDTH-1:0] alloc_data,
    input  logic [TAG_WIDTH-1:0]  alloc_tag,
    output logic                  lsb_free,
    output logic [1:0]            rw_flag,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [1:0]            len,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  mem_busy,
    input  logic                  mem_done,
    output logic                  rst_en,
    output logic [TAG_WIDTH-1:0]  rst_tag,
    output logic [DATA_WIDTH-1:0] rst_data
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

    logic [3:0]            op_mem   [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_mem  [DEPTH];

    state_e                state_q, state_d;
    logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [1:0]            rw_flag_q, rw_flag_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            len_q, len_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rst_en_q, rst_en_d;
    logic [TAG_WIDTH-1:0]  rst_tag_q, rst_tag_d;
    logic [DATA_WIDTH-1:0] rst_data_q, rst_data_d;

    logic                  push, pop, issue;
    logic [3:0]            head_op;

    function automatic logic [1:0] size_to_len(input logic [1:0] size);
        case (size)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // op = {is_store, is_unsigned, size}
    function automatic logic [DATA_WIDTH-1:0] extend(input logic [3:0] op,
                                                     input logic [DATA_WIDTH-1:0] din);
        logic sgn;
        sgn = ~op[2];
        case (op[1:0])
            2'd0:    return {{(DATA_WIDTH-8){sgn & din[7]}}, din[7:0]};
            2'd1:    return {{(DATA_WIDTH-16){sgn & din[15]}}, din[15:0]};
            default: return din;
        endcase
    endfunction

    assign head_op = op_mem[head_q];
    assign push    = alloc_en && (count_q < CntW'(DEPTH));
    assign pop     = (state_q == StReq) && mem_done;

    // Payload storage needs no reset; validity is tracked by head/tail/count.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[tail_q]   <= alloc_op;
            addr_mem[tail_q] <= alloc_addr;
            data_mem[tail_q] <= alloc_data;
            tag_mem[tail_q]  <= alloc_tag;
        end
    end

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rw_flag_d  = rw_flag_q;
        addr_d     = addr_q;
        len_d      = len_q;
        data_out_d = data_out_q;
        rst_en_d   = 1'b0;
        rst_tag_d  = rst_tag_q;
        rst_data_d = rst_data_q;
        issue      = 1'b0;

        if (push) begin
            tail_d = tail_q + PtrW'(1);
        end
        if (pop) begin
            head_d = head_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    issue = 1'b1;
                end
            end
            StReq: begin
                if (mem_done) begin
                    rw_flag_d  = 2'b00;
                    rst_en_d   = 1'b1;
                    rst_tag_d  = tag_mem[head_q];
                    rst_data_d = head_op[3] ? '0 : extend(head_op, data_in);
                    state_d    = StGap;
                end
            end
            StGap: begin
                // head_q already points past the op that just completed
                if (count_q != '0) begin
                    issue = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (issue) begin
            rw_flag_d  = head_op[3] ? 2'b10 : 2'b01;
            addr_d     = addr_mem[head_q];
            len_d      = size_to_len(head_op[1:0]);
            data_out_d = data_mem[head_q];
            state_d    = StReq;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rw_flag_q  <= 2'b00;
            addr_q     <= '0;
            len_q      <= 2'd0;
            data_out_q <= '0;
            rst_en_q   <= 1'b0;
            rst_tag_q  <= '0;
            rst_data_q <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rw_flag_q  <= rw_flag_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            data_out_q <= data_out_d;
            rst_en_q   <= rst_en_d;
            rst_tag_q  <= rst_tag_d;
            rst_data_q <= rst_data_d;
        end
    end

    // mem_busy only delays mem_done; request outputs are held regardless.
    logic unused_busy;
    assign unused_busy = mem_busy;

    assign lsb_free = (count_q < CntW'(DEPTH - 1));
    assign rw_flag  = rw_flag_q;
    assign addr     = addr_q;
    assign len      = len_q;
    assign data_out = data_out_q;
    assign rst_en   = rst_en_q;
    assign rst_tag  = rst_tag_q;
    assign rst_data = rst_data_q;

endmodule
